// File: rtl/bubble_ctrl_conditioner_if.sv
// Bubble control bus between the host-side pins, the conditioner and the
// emulator core.
//   nEN                     module enable, active-low
//   nBSS_IN .. nSWAPEN_IN   raw asynchronous host controls, active-low
//   SEQERR_CLR              synchronous clear pulse for SEQERR
//   nBSS .. nSWAPEN         filtered controls to the emulator core
//   FALLSTB / RISESTB       one-cycle edge strobes (0=BSS 1=BSEN 2=REPEN 3=BOOTEN 4=SWAPEN)
//   SEQSTATE                monitor state (0=IDLE 1=STANDBY 2=ACCESS)
//   SEQERR                  sticky protocol-error flag
//   ACCESSCNT               saturating count of ACCESS entries
// master: host/core side; slave: the conditioner.
interface bubble_ctrl_conditioner_if;
    logic        nEN;
    logic        nBSS_IN, nBSEN_IN, nREPEN_IN, nBOOTEN_IN, nSWAPEN_IN;
    logic        SEQERR_CLR;
    logic        nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN;
    logic [4:0]  FALLSTB;
    logic [4:0]  RISESTB;
    logic [1:0]  SEQSTATE;
    logic        SEQERR;
    logic [15:0] ACCESSCNT;

    modport master (
        output nEN, nBSS_IN, nBSEN_IN, nREPEN_IN, nBOOTEN_IN, nSWAPEN_IN, SEQERR_CLR,
        input  nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN, FALLSTB, RISESTB,
               SEQSTATE, SEQERR, ACCESSCNT
    );

    modport slave (
        input  nEN, nBSS_IN, nBSEN_IN, nREPEN_IN, nBOOTEN_IN, nSWAPEN_IN, SEQERR_CLR,
        output nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN, FALLSTB, RISESTB,
               SEQSTATE, SEQERR, ACCESSCNT
    );
endinterface

// File: rtl/bubble_ctrl_conditioner.sv
// Bubble control conditioner: synchronises the five raw host controls into
// the MCLK domain, glitch-filters them, produces edge strobes, and runs a
// BSS/BSEN sequence monitor with a sticky error flag and an access counter.
// Ports:
//   MCLK    48 MHz system clock
//   nRESET  asynchronous active-low reset
//   bus     bubble_ctrl_conditioner_if.slave (controls, strobes, monitor)
module bubble_ctrl_conditioner #(
    parameter int unsigned FILTER_LEN = 8,   // 1..15
    parameter int unsigned CNT_W      = 4    // 2**CNT_W > FILTER_LEN
) (
    input  logic                        MCLK,
    input  logic                        nRESET,
    bubble_ctrl_conditioner_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STANDBY = 2'd1,
        ACCESS  = 2'd2
    } seq_t;

    logic [4:0]       raw;
    logic [4:0]       sync1, sync2;
    logic [4:0]       filt, filt_nxt, tog;
    logic [4:0]       fall_q, rise_q;
    logic [CNT_W-1:0] cnt     [5];
    logic [CNT_W-1:0] cnt_nxt [5];

    seq_t             state;
    logic             seqerr;
    logic [15:0]      acc_cnt;

    assign raw = {bus.nSWAPEN_IN, bus.nBOOTEN_IN, bus.nREPEN_IN, bus.nBSEN_IN, bus.nBSS_IN};

    // Filter: a new level must be seen on FILTER_LEN consecutive samples;
    // any agreeing sample restarts the count. Disabled -> inactive, idle.
    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            tog[i]      = 1'b0;
            cnt_nxt[i]  = '0;
            filt_nxt[i] = 1'b1;
            if (!bus.nEN) begin
                filt_nxt[i] = filt[i];
                if (sync2[i] != filt[i]) begin
                    if (cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
                        tog[i]      = 1'b1;
                        filt_nxt[i] = ~filt[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Strobes are registered together with the filtered level so they line
    // up with the cycle in which the filtered output changes.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            fall_q <= '0;
            rise_q <= '0;
            cnt    <= '{default: '0};
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt   <= filt_nxt;
            cnt    <= cnt_nxt;
            fall_q <= tog & filt;
            rise_q <= tog & ~filt;
        end
    end

    // Sequence monitor. A clear pulse is scheduled first so that an error
    // raised in the same cycle overrides it.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= IDLE;
            seqerr  <= 1'b0;
            acc_cnt <= '0;
        end else if (bus.nEN) begin
            state <= IDLE;
        end else begin
            if (bus.SEQERR_CLR)
                seqerr <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_q[0]) begin
                        if (fall_q[1]) begin
                            state <= ACCESS;
                            if (acc_cnt != '1)
                                acc_cnt <= acc_cnt + 16'd1;
                        end else begin
                            state <= STANDBY;
                        end
                    end else if (fall_q[1]) begin
                        seqerr <= 1'b1;
                    end
                end
                STANDBY: begin
                    if (fall_q[1]) begin
                        state <= ACCESS;
                        if (acc_cnt != '1)
                            acc_cnt <= acc_cnt + 16'd1;
                    end else if (rise_q[0]) begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (rise_q[0]) begin
                        state <= IDLE;
                        if (!rise_q[1])
                            seqerr <= 1'b1;
                    end else if (rise_q[1]) begin
                        state <= STANDBY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.nBSS      = filt[0];
    assign bus.nBSEN     = filt[1];
    assign bus.nREPEN    = filt[2];
    assign bus.nBOOTEN   = filt[3];
    assign bus.nSWAPEN   = filt[4];
    assign bus.FALLSTB   = fall_q;
    assign bus.RISESTB   = rise_q;
    assign bus.SEQSTATE  = state;
    assign bus.SEQERR    = seqerr;
    assign bus.ACCESSCNT = acc_cnt;

endmodule

// File: tb/tb_bubble_ctrl_conditioner.sv
// Testbench for bubble_ctrl_conditioner: directed scenarios with literal
// expectations, then randomized stimulus, all checked against a windowed
// behavioural model of the filters and the sequence rules.
module tb_bubble_ctrl_conditioner;
    localparam int FL = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_fail = 0;

    bubble_ctrl_conditioner_if bus ();

    bubble_ctrl_conditioner #(.FILTER_LEN(FL), .CNT_W(4)) dut (
        .MCLK   (clk),
        .nRESET (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0]  r1, r2, mf, mfall, mrise;
    int          mstate;
    logic        merr;
    logic [15:0] mcnt;
    logic [4:0]  sh  [16];
    logic        enh [16];
    int          lastchg [5];
    int          ecount = 0;
    int          preset_req = 0;
    int          preset_seen = 0;

    // Filtered level flips once the last FL samples were all enabled, all
    // disagreed with it, and it has not changed within that window.
    initial forever begin : model
        logic [4:0] raw, s, tg;
        logic       en, clr, err_new, ok;
        int         idx;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            r1 = '1; r2 = '1; mf = '1; mfall = '0; mrise = '0;
            mstate = 0; merr = 1'b0; mcnt = '0;
            for (int i = 0; i < 5; i++) lastchg[i] = ecount;
        end else begin
            ecount++;
            raw = {bus.nSWAPEN_IN, bus.nBOOTEN_IN, bus.nREPEN_IN, bus.nBSEN_IN, bus.nBSS_IN};
            en  = !bus.nEN;
            clr = bus.SEQERR_CLR;
            if (preset_req != preset_seen) begin
                mcnt = 16'hFFFE;
                preset_seen = preset_req;
            end
            if (!en) begin
                mstate = 0;
            end else begin
                err_new = 1'b0;
                case (mstate)
                    0: if (mfall[0] && mfall[1]) begin
                           mstate = 2; if (mcnt != 16'hFFFF) mcnt++;
                       end else if (mfall[0]) mstate = 1;
                       else if (mfall[1]) err_new = 1'b1;
                    1: if (mfall[1]) begin
                           mstate = 2; if (mcnt != 16'hFFFF) mcnt++;
                       end else if (mrise[0]) mstate = 0;
                    default: if (mrise[0]) begin
                           mstate = 0; if (!mrise[1]) err_new = 1'b1;
                       end else if (mrise[1]) mstate = 1;
                endcase
                if (err_new) merr = 1'b1;
                else if (clr) merr = 1'b0;
            end
            s = r2; r2 = r1; r1 = raw;
            sh[ecount % 16]  = s;
            enh[ecount % 16] = en;
            for (int i = 0; i < 5; i++) begin
                ok = (ecount - lastchg[i] >= FL);
                for (int k = 0; k < FL; k++) begin
                    idx = (ecount - k) % 16;
                    ok = ok && enh[idx] && (sh[idx][i] != mf[i]);
                end
                tg[i] = ok;
            end
            mfall = tg & mf;
            mrise = tg & ~mf;
            for (int i = 0; i < 5; i++)
                if (tg[i]) begin
                    mf[i] = ~mf[i];
                    lastchg[i] = ecount;
                end
            if (!en) mf = '1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            chk("filtered", 32'({bus.nSWAPEN, bus.nBOOTEN, bus.nREPEN, bus.nBSEN, bus.nBSS}), 32'(mf));
            chk("fallstb",  32'(bus.FALLSTB),   32'(mfall));
            chk("risestb",  32'(bus.RISESTB),   32'(mrise));
            chk("seqstate", 32'(bus.SEQSTATE),  32'(mstate));
            chk("seqerr",   32'(bus.SEQERR),    32'(merr));
            chk("accesscnt",32'(bus.ACCESSCNT), 32'(mcnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic access_seq();
        bus.nBSS_IN  = 1'b0; wait_n(12);
        bus.nBSEN_IN = 1'b0; wait_n(12);
        bus.nBSEN_IN = 1'b1; wait_n(12);
        bus.nBSS_IN  = 1'b1; wait_n(12);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_filt"}, 32'({bus.nSWAPEN, bus.nBOOTEN, bus.nREPEN, bus.nBSEN, bus.nBSS}), 32'h1F);
        chk({tag, "_strb"}, 32'({bus.FALLSTB, bus.RISESTB}), 32'h0);
        chk({tag, "_state"}, 32'(bus.SEQSTATE), 32'd0);
        chk({tag, "_err"}, 32'(bus.SEQERR), 32'd0);
        chk({tag, "_cnt"}, 32'(bus.ACCESSCNT), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.nEN = 1'b1;
        bus.nBSS_IN = 1'b1; bus.nBSEN_IN = 1'b1; bus.nREPEN_IN = 1'b1;
        bus.nBOOTEN_IN = 1'b1; bus.nSWAPEN_IN = 1'b1;
        bus.SEQERR_CLR = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        bus.nEN = 1'b0;
        chk_reset_vals("reset");
        wait_n(20);
        chk_reset_vals("idle_en");

        // nBSS fall: filtered edge exactly 10 cycles after the input edge
        bus.nBSS_IN = 1'b0;
        wait_n(9);
        chk("bss_before", 32'(bus.nBSS), 32'd1);
        wait_n(1);
        chk("bss_fall", 32'(bus.nBSS), 32'd0);
        chk("bss_fallstb", 32'(bus.FALLSTB), 32'h01);
        wait_n(1);
        chk("bss_stb_width", 32'(bus.FALLSTB), 32'h00);
        chk("standby", 32'(bus.SEQSTATE), 32'd1);

        // nBSEN glitches shorter than the filter window
        bus.nBSEN_IN = 1'b0; wait_n(5);
        bus.nBSEN_IN = 1'b1; wait_n(3);
        bus.nBSEN_IN = 1'b0; wait_n(5);
        bus.nBSEN_IN = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk("glitch_nbsen", 32'({bus.nBSEN, bus.FALLSTB}), 32'h20);
            wait_n(1);
        end

        // complete sequence from STANDBY
        bus.nBSEN_IN = 1'b0; wait_n(12);
        chk("seq_access", 32'(bus.SEQSTATE), 32'd2);
        chk("seq_cnt1", 32'(bus.ACCESSCNT), 32'd1);
        bus.nBSEN_IN = 1'b1; wait_n(12);
        chk("seq_standby", 32'(bus.SEQSTATE), 32'd1);
        bus.nBSS_IN = 1'b1; wait_n(12);
        chk("seq_idle", 32'(bus.SEQSTATE), 32'd0);
        chk("seq_noerr", 32'(bus.SEQERR), 32'd0);

        // protocol errors and clear
        bus.nBSEN_IN = 1'b0; wait_n(12);
        chk("err_bsen_idle", 32'({bus.SEQERR, bus.SEQSTATE}), 32'h4);
        bus.SEQERR_CLR = 1'b1; wait_n(1);
        bus.SEQERR_CLR = 1'b0;
        chk("err_clr", 32'(bus.SEQERR), 32'd0);
        bus.nBSEN_IN = 1'b1; wait_n(12);
        bus.nBSS_IN  = 1'b0; wait_n(12);
        bus.nBSEN_IN = 1'b0; wait_n(12);
        chk("err_cnt2", 32'(bus.ACCESSCNT), 32'd2);
        bus.nBSS_IN  = 1'b1; wait_n(12);
        chk("err_bss_access", 32'({bus.SEQERR, bus.SEQSTATE}), 32'h4);
        bus.nBSEN_IN = 1'b1; wait_n(12);
        bus.SEQERR_CLR = 1'b1; wait_n(1);
        bus.SEQERR_CLR = 1'b0;

        // saturation
        #2;
        force dut.acc_cnt = 16'hFFFE;
        preset_req++;
        #1;
        release dut.acc_cnt;
        wait_n(1);
        chk("preset", 32'(bus.ACCESSCNT), 32'hFFFE);
        access_seq();
        chk("sat_1", 32'(bus.ACCESSCNT), 32'hFFFF);
        access_seq();
        access_seq();
        chk("sat_3", 32'(bus.ACCESSCNT), 32'hFFFF);

        // asynchronous reset in the middle of an access
        bus.nBSS_IN  = 1'b0; wait_n(12);
        bus.nBSEN_IN = 1'b0; wait_n(12);
        chk("pre_reset_access", 32'(bus.SEQSTATE), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        bus.nBSS_IN = 1'b1; bus.nBSEN_IN = 1'b1;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(5);

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) bus.nBSS_IN     = ~bus.nBSS_IN;
            if ($urandom_range(0, 13) == 0) bus.nBSEN_IN    = ~bus.nBSEN_IN;
            if ($urandom_range(0, 11) == 0) bus.nREPEN_IN   = ~bus.nREPEN_IN;
            if ($urandom_range(0, 9)  == 0) bus.nBOOTEN_IN  = ~bus.nBOOTEN_IN;
            if ($urandom_range(0, 7)  == 0) bus.nSWAPEN_IN  = ~bus.nSWAPEN_IN;
            if (!bus.nEN && $urandom_range(0, 399) == 0) bus.nEN = 1'b1;
            else if (bus.nEN && $urandom_range(0, 29) == 0) bus.nEN = 1'b0;
            bus.SEQERR_CLR = ($urandom_range(0, 49) == 0);
            wait_n(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bubble_ctrl_conditioner.md
Name: bubble_ctrl_conditioner

Overview:
- Upstream front end of the bubble emulator core. Takes the raw, asynchronous bubble control inputs from the host board: nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN.
- Synchronises each input into the 48 MHz MCLK domain, glitch-filters it, and drives clean versions to the emulator core's control inputs.
- Also produces per-signal edge strobes, a BSS/BSEN sequence monitor with a sticky protocol-error flag, and a saturating access counter for diagnostics.

Parameters:
- FILTER_LEN, 8, consecutive MCLK samples a synchronised input must hold a new level before the filtered output follows (range 1..15).
- CNT_W, 4, filter counter width; must satisfy 2^CNT_W > FILTER_LEN.

Ports:
- MCLK  in  1  48 MHz system clock; sole clock.
- nRESET  in  1  asynchronous active-low reset.
- nEN  in  1  module enable, active-low; same signal as the emulator core enable.
- nBSS_IN, nBSEN_IN, nREPEN_IN, nBOOTEN_IN, nSWAPEN_IN  in  1 each  raw host control inputs, asynchronous, active-low.
- nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN  out  1 each  filtered controls, to the emulator core.
- FALLSTB  out  5  one-cycle strobe on a filtered 1->0 transition. Bit order: 0=BSS, 1=BSEN, 2=REPEN, 3=BOOTEN, 4=SWAPEN.
- RISESTB  out  5  one-cycle strobe on a filtered 0->1 transition; same bit order.
- SEQSTATE  out  2  monitor state: 0=IDLE, 1=STANDBY, 2=ACCESS.
- SEQERR  out  1  sticky protocol-error flag.
- SEQERR_CLR  in  1  synchronous clear pulse for SEQERR.
- ACCESSCNT  out  16  count of ACCESS entries, saturating.

Behaviour:
- Clock/reset: one clock, MCLK. Reset is asynchronous, active-low on nRESET.
- Reset values:
  - all five filtered outputs = 1;
  - FALLSTB = RISESTB = 0;
  - SEQSTATE = IDLE; SEQERR = 0; ACCESSCNT = 0;
  - synchroniser flops = 1; filter counters = 0.
- Synchroniser: two flops per input, no logic between them.
- Filter, per signal, with counter C:
  - sync output == filtered output: C <= 0.
  - otherwise: C <= C+1.
  - when C == FILTER_LEN-1 and the mismatch persists: filtered output toggles and C <= 0.
  - Any single-cycle match restarts the count.
- Latency: input edge to filtered edge = 2 + FILTER_LEN MCLK cycles (10 cycles at default).
- Strobes: FALLSTB/RISESTB bit asserts in the same cycle the filtered output changes (registered compare against previous value). Width is exactly one cycle.
- nEN high:
  - synchronisers keep sampling;
  - filtered outputs forced 1 and counters held 0;
  - no strobes; FSM forced IDLE; ACCESSCNT and SEQERR hold.
- nEN 1->0: filters resume from the all-inactive state. An input already low produces a falling strobe after FILTER_LEN cycles.
- Sequence FSM, driven by filtered strobes:
  - IDLE -> STANDBY on FALLSTB[0].
  - IDLE + FALLSTB[1] -> SEQERR set, remain IDLE.
  - STANDBY -> ACCESS on FALLSTB[1]; ACCESSCNT += 1, saturating at 0xFFFF.
  - STANDBY -> IDLE on RISESTB[0].
  - ACCESS -> STANDBY on RISESTB[1].
  - ACCESS -> IDLE on RISESTB[0] without RISESTB[1]; SEQERR set.
- Simultaneous events:
  - RISESTB[0] and RISESTB[1] together in ACCESS: -> IDLE, no error.
  - FALLSTB[0] and FALLSTB[1] together in IDLE: -> ACCESS, count increments, no error.
  - SEQERR_CLR coincident with a new error: error wins, SEQERR stays 1.
- nREPEN/nBOOTEN/nSWAPEN: filtered and strobed only; no FSM involvement.

Test Plan:
- Reset then nEN=0, all inputs 1 -> all filtered outputs 1, no strobes, SEQSTATE=0, ACCESSCNT=0.
- nBSS_IN low at cycle 0, held -> nBSS falls at cycle 10, FALLSTB=5'b00001 for one cycle, SEQSTATE=1.
- nBSEN_IN glitch low for 5 cycles, then 3 cycles high, then low 5 -> no change on nBSEN, no strobe.
- Full sequence BSS fall, BSEN fall, BSEN rise, BSS rise -> SEQSTATE 1,2,1,0; ACCESSCNT=1; SEQERR=0.
- nBSEN fall with nBSS high -> SEQERR=1, SEQSTATE=0. Pulse SEQERR_CLR -> SEQERR=0. Next cycle, nBSS rise while in ACCESS -> SEQERR=1.
- Force ACCESSCNT to 0xFFFE, run 3 access sequences -> counter stops at 0xFFFF. Assert nRESET mid-access -> all outputs return to reset values immediately.
